centipede_hiscore: RTL and testbench

CENTIPEDE_HISCORE -- requirements
Module: centipede_hiscore

---
 rtl/centipede_hiscore_pkg.sv | 12 +
 rtl/centipede_hiscore.sv | 110 +++++++++++
 tb/tb_centipede_hiscore.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/centipede_hiscore_pkg.sv
// Shared constants for the Centipede high-score dump/restore port.
package centipede_hiscore_pkg;

  localparam int unsigned RAM_AW = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IOCTL_AW = 25;

  localparam logic [7:0]        DUMP_INDEX_DEF = 8'd4;
  localparam logic [RAM_AW-1:0] HS_BASE_DEF    = 10'h000;
  localparam logic [10:0]       HS_LENGTH_DEF  = 11'd64;

endpackage

// File: rtl/centipede_hiscore.sv
// High-score save/restore bridge between the HPS ioctl bus and game RAM.
// Upload reads game RAM with a two-cycle address-to-data latency, download
// writes game RAM one cycle after each accepted strobe, and hs_loaded latches
// once a download that wrote at least one byte has ended.
module centipede_hiscore
  import centipede_hiscore_pkg::*;
#(
  parameter logic [7:0]        DUMP_INDEX = DUMP_INDEX_DEF,
  parameter logic [RAM_AW-1:0] BASE_ADDR  = HS_BASE_DEF,
  parameter logic [10:0]       LENGTH     = HS_LENGTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ioctl_upload,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [DATA_W-1:0]   ioctl_dout,
  input  logic [DATA_W-1:0]   ioctl_din,
  input  logic [7:0]          ioctl_index,
  output logic [RAM_AW-1:0]   ram_address,
  output logic                ram_wr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W-1:0]   upload_data,
  output logic                hs_loaded
);

  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] upload_data_q, upload_data_d;
  logic              hs_loaded_q, hs_loaded_d;
  logic              wr_seen_q, wr_seen_d;
  logic              dl_q;

  logic              idx_hit;
  logic              addr_ok;
  logic              sel;
  logic [RAM_AW-1:0] tgt_addr;

  // Address window: full 25-bit compare, so high address bits never alias.
  assign idx_hit  = (ioctl_index == DUMP_INDEX);
  assign addr_ok  = (ioctl_addr < IOCTL_AW'(LENGTH));
  assign sel      = idx_hit && addr_ok;
  assign tgt_addr = BASE_ADDR + ioctl_addr[RAM_AW-1:0];

  // Next-state: download beats upload; idle parks the RAM address at the base.
  always_comb begin
    ram_addr_d    = ram_addr_q;
    ram_wr_d      = 1'b0;
    ram_wdata_d   = ram_wdata_q;
    upload_data_d = upload_data_q;
    wr_seen_d     = wr_seen_q;
    hs_loaded_d   = hs_loaded_q;

    if (ioctl_download) begin
      if (ioctl_wr && sel) begin
        ram_addr_d  = tgt_addr;
        ram_wr_d    = 1'b1;
        ram_wdata_d = ioctl_dout;
        wr_seen_d   = 1'b1;
      end
    end else if (ioctl_upload && idx_hit) begin
      if (addr_ok) begin
        ram_addr_d    = tgt_addr;
        upload_data_d = ioctl_din;
      end else begin
        upload_data_d = '0;
      end
    end else begin
      ram_addr_d = BASE_ADDR;
    end

    // Falling edge of download closes the restore; arm again for the next one.
    if (dl_q && !ioctl_download) begin
      if (wr_seen_q) begin
        hs_loaded_d = 1'b1;
      end
      wr_seen_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr_q    <= BASE_ADDR;
      ram_wr_q      <= 1'b0;
      ram_wdata_q   <= '0;
      upload_data_q <= '0;
      hs_loaded_q   <= 1'b0;
      wr_seen_q     <= 1'b0;
      dl_q          <= 1'b0;
    end else begin
      ram_addr_q    <= ram_addr_d;
      ram_wr_q      <= ram_wr_d;
      ram_wdata_q   <= ram_wdata_d;
      upload_data_q <= upload_data_d;
      hs_loaded_q   <= hs_loaded_d;
      wr_seen_q     <= wr_seen_d;
      dl_q          <= ioctl_download;
    end
  end

  assign ram_address = ram_addr_q;
  assign ram_wr      = ram_wr_q;
  assign ram_wdata   = ram_wdata_q;
  assign upload_data = upload_data_q;
  assign hs_loaded   = hs_loaded_q;

endmodule

// File: tb/tb_centipede_hiscore.sv
// Directed bench for centipede_hiscore: upload latency, download strobes,
// window rejection, address wrap and reset abort.
module tb_centipede_hiscore;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_upload, ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_din, ioctl_index;

  logic [9:0]  ram_address, w_ram_address;
  logic        ram_wr, w_ram_wr;
  logic [7:0]  ram_wdata, w_ram_wdata, upload_data, w_upload_data;
  logic        hs_loaded, w_hs_loaded;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Game RAM model: data follows the registered address within the cycle.
  assign ioctl_din = ram_address[7:0] ^ 8'hA5;

  centipede_hiscore dut (
    .clk(clk), .reset(reset),
    .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_index(ioctl_index),
    .ram_address(ram_address), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
    .upload_data(upload_data), .hs_loaded(hs_loaded)
  );

  centipede_hiscore #(.BASE_ADDR(10'h3F0)) dut_wrap (
    .clk(clk), .reset(reset),
    .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_index(ioctl_index),
    .ram_address(w_ram_address), .ram_wr(w_ram_wr), .ram_wdata(w_ram_wdata),
    .upload_data(w_upload_data), .hs_loaded(w_hs_loaded)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks both happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  32'(ram_address), 32'h000);
    check({tag, "_wr"},    32'(ram_wr),      32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata),   32'h00);
    check({tag, "_up"},    32'(upload_data), 32'h00);
    check({tag, "_hs"},    32'(hs_loaded),   32'd0);
  endtask

  initial begin
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = 8'd4;
    step(); step();
    check_reset_vals("rst");
    check("rst_wrap_addr", 32'(w_ram_address), 32'h3F0);
    reset = 1'b0;

    // Upload sweep 0..63; last address held one extra cycle to drain the pipe.
    ioctl_upload = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      ioctl_addr = 25'((k > 63) ? 63 : k);
      step();
      check($sformatf("up_addr%0d", k), 32'(ram_address), 32'((k > 63) ? 63 : k));
      if (k >= 1)
        check($sformatf("up_data%0d", k), 32'(upload_data), 32'(8'(k - 1) ^ 8'hA5));
    end

    // Out-of-window upload: address holds, data forced to zero.
    ioctl_addr = 25'd64; step();
    check("up_oob_addr", 32'(ram_address), 32'd63);
    check("up_oob_data", 32'(upload_data), 32'h00);

    ioctl_addr = 25'd10; step();
    check("up10_first", 32'(upload_data), 32'(8'd63 ^ 8'hA5));
    step();
    check("up10_data", 32'(upload_data), 32'(8'd10 ^ 8'hA5));

    // Idle parks address, holds upload data.
    ioctl_upload = 1'b0; step();
    check("idle_addr", 32'(ram_address), 32'h000);
    check("idle_up_hold", 32'(upload_data), 32'(8'd10 ^ 8'hA5));
    check("idle_wr", 32'(ram_wr), 32'd0);

    // Rejected writes: addr 64, addr 0x400, index 3.
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_dout = 8'h77;
    ioctl_addr = 25'd64; step();
    check("rej_addr64", 32'(ram_wr), 32'd0);
    ioctl_addr = 25'h400; step();
    check("rej_addr400", 32'(ram_wr), 32'd0);
    ioctl_addr = 25'd0; ioctl_index = 8'd3; step();
    check("rej_idx3", 32'(ram_wr), 32'd0);
    ioctl_wr = 1'b0; ioctl_index = 8'd4; step();
    check("rej_wr_low", 32'(ram_wr), 32'd0);
    ioctl_download = 1'b0; step(); step();
    check("rej_hs", 32'(hs_loaded), 32'd0);

    // Single accepted write 0x3F -> 5.
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h3F; step();
    check("dl5_wr", 32'(ram_wr), 32'd1);
    check("dl5_addr", 32'(ram_address), 32'd5);
    check("dl5_data", 32'(ram_wdata), 32'h3F);
    check("dl5_wrap_addr", 32'(w_ram_address), 32'h3F5);
    ioctl_wr = 1'b0; step();
    check("dl5_pulse_end", 32'(ram_wr), 32'd0);
    check("dl5_hs_early", 32'(hs_loaded), 32'd0);
    ioctl_download = 1'b0; step();
    check("dl5_hs", 32'(hs_loaded), 32'd1);
    check("dl5_idle_addr", 32'(ram_address), 32'h000);

    // Back-to-back strobes, plus wrap at base 0x3F0.
    ioctl_download = 1'b1; ioctl_wr = 1'b1;
    ioctl_addr = 25'd7; ioctl_dout = 8'h11; step();
    check("b2b_wr0", 32'(ram_wr), 32'd1);
    check("b2b_addr0", 32'(ram_address), 32'd7);
    ioctl_addr = 25'h20; ioctl_dout = 8'h22; step();
    check("b2b_wr1", 32'(ram_wr), 32'd1);
    check("b2b_data1", 32'(ram_wdata), 32'h22);
    check("wrap_addr", 32'(w_ram_address), 32'h010);
    check("nowrap_addr", 32'(ram_address), 32'h020);

    // Upload and download together: download wins, upload data held.
    ioctl_wr = 1'b0; ioctl_upload = 1'b1; step();
    check("both_wr", 32'(ram_wr), 32'd0);
    check("both_up_hold", 32'(upload_data), 32'(8'd10 ^ 8'hA5));
    ioctl_upload = 1'b0; ioctl_download = 1'b0; step();
    check("hs_sticky", 32'(hs_loaded), 32'd1);

    // Reset mid-download after three writes, then download falls.
    ioctl_download = 1'b1; ioctl_wr = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      ioctl_addr = 25'(k); ioctl_dout = 8'(8'h40 + k); step();
      check($sformatf("pre_rst_wr%0d", k), 32'(ram_wr), 32'd1);
    end
    ioctl_wr = 1'b0; reset = 1'b1; step();
    check_reset_vals("mid_rst");
    reset = 1'b0; step();
    ioctl_download = 1'b0; step();
    step();
    check_reset_vals("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
